alu_issue_arbiter: RTL and testbench
====================================

// Module: alu_issue_arbiter
// PURPOSE
//  Shares the single combinational ALU between two requesters (req0 = datapath, req1 = address/PC unit).
//  Round-robin grant, latched operands, multi-cycle settle window, registered result/flags.
//  Owns the architectural condition-code register (C,N,V,Z) and feeds the stored C into ALU Cin on request.
//  Sits between the requesters and the ALU instance; the ALU itself is unchanged.
// PARAMETERS
//  WIDTH        32  operand/result width
//  OPW          4   ALU op-code width
//  EXEC_CYCLES  1   cycles operands are held on ALU before sampling (>=1)
// PORTS
//  clk           in   1      system clock, rising edge
//  rst_n         in   1      asynchronous active-low reset
//  reqN_valid    in   1      request N (N=0,1) presents an op
//  reqN_ready    out  1      request N accepted this cycle (valid&ready = transfer)
//  reqN_op       in   OPW    ALU op code
//  reqN_a        in   WIDTH  operand A
//  reqN_b        in   WIDTH  operand B
//  reqN_setcc    in   1      write result flags into CC register
//  reqN_usec     in   1      drive ALU Cin from stored CC.C (else Cin=0)
//  resp_valid    out  1      result available
//  resp_ready    in   1      consumer takes result
//  resp_id       out  1      requester that owns the result
//  resp_result   out  WIDTH  registered ALU result
//  resp_flags    out  4      registered {C,N,V,Z} of that op
//  alu_a, alu_b  out  WIDTH  to ALU inputs
//  alu_cin       out  1      to ALU carry in
//  alu_op        out  OPW    to ALU op
//  alu_result    in   WIDTH  from ALU
//  alu_c/n/v/z   in   1 each from ALU flags
//  cc_flags      out  4      architectural {C,N,V,Z}
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, all outputs 0, cc_flags=0, last_grant=1 (req0 wins first tie).
//  FSM IDLE -> EXEC -> RESP -> IDLE.
//  IDLE: reqN_ready combinational = grant; grant = only valid requester, or on tie the one != last_grant.
//   At edge with transfer: latch op/a/b/setcc/usec/id, last_grant=id, cnt=0, go EXEC. No valid: stay IDLE.
//  EXEC: alu_* driven from latched regs (stable whole state); alu_cin = usec ? cc_flags[3] : 0.
//   cnt increments each edge; at edge where cnt==EXEC_CYCLES-1: capture alu_result/flags into resp_*,
//   if setcc cc_flags<={alu_c,alu_n,alu_v,alu_z}; go RESP.
//  RESP: resp_valid=1; hold resp_* stable until resp_valid&resp_ready edge, then IDLE.
//  reqN_ready=0 outside IDLE; resp_valid=0 outside RESP. alu_* keep last latched values when idle.
//  Latency: acceptance edge k -> resp_valid high after edge k+EXEC_CYCLES. Throughput 1 op / EXEC_CYCLES+2 clk.
//  cc_flags changes only at capture edge; next op's usec sees updated C (no hazard, ops serialised).
//  Requester deasserting valid before ready: no grant, no state change. ready never asserted without valid.
//  resp_ready held low: block stalls in RESP; both requesters see ready=0.
//  Reset mid-op: op discarded, no response, cc_flags cleared.
//  Arithmetic/flag semantics belong to ALU; block never modifies result or flags.
// TESTING
//  1 Reset: rst_n=0 mid-EXEC -> resp_valid=0, ready=0, cc_flags=0 immediately, state IDLE after release.
//  2 Single op: req0 op=0 A=83 B=101 setcc=1 -> resp_result=184, resp_id=0, flags 0000, resp_valid 1 clk after accept.
//  3 Tie: req0,req1 valid together twice -> grants 0 then 1; third tie after req1 grant -> 0.
//  4 Overflow/CC: req1 op=0 A=0x7FFFFFFF B=2 setcc=1 -> result 0x80000001, flags N=1 V=1, cc_flags=4'b0110.
//  5 Carry chain: op A=0xFFFFFFFF B=1 setcc=1 (C=1), then usec=1 A=5 B=5 -> alu_cin=1, result 11.
//  6 Backpressure: resp_ready=0 for 5 clk with both valid -> result stable, no ready pulses; EXEC_CYCLES=3 rerun -> latency 3.

Source files
------------

// File: rtl/alu_issue_arbiter_if.sv
// Request/response bundle between the two ALU requesters and alu_issue_arbiter.
// Transfer rule: an item moves on a rising clk edge where valid && ready are both high; the
// producer holds its payload stable while valid is high and ready is low, and ready is never
// raised for a side whose valid is low.
interface alu_issue_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [OPW-1:0]   req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_setcc;
  logic             req0_usec;

  logic             req1_valid;
  logic             req1_ready;
  logic [OPW-1:0]   req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_setcc;
  logic             req1_usec;

  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [WIDTH-1:0] resp_result;
  logic [3:0]       resp_flags;

  // Requester/consumer side
  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req0_setcc, req0_usec,
    output req1_valid, req1_op, req1_a, req1_b, req1_setcc, req1_usec,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, resp_result, resp_flags
  );

  // Arbiter side
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req0_setcc, req0_usec,
    input  req1_valid, req1_op, req1_a, req1_b, req1_setcc, req1_usec,
    input  resp_ready,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, resp_result, resp_flags
  );
endinterface

// File: rtl/alu_issue_arbiter.sv
// Round-robin issue of two requesters onto one shared combinational ALU, with latched operands,
// a fixed settle window, registered result/flags and the architectural {C,N,V,Z} register.
module alu_issue_arbiter #(
  parameter int WIDTH       = 32,
  parameter int OPW         = 4,
  parameter int EXEC_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_issue_arbiter_if.slave   bus,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic                 alu_cin,
  output logic [OPW-1:0]       alu_op,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic                 alu_c,
  input  logic                 alu_n,
  input  logic                 alu_v,
  input  logic                 alu_z,
  output logic [3:0]           cc_flags,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(EXEC_CYCLES - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             last_grant;

  logic [OPW-1:0]   lat_op;
  logic [WIDTH-1:0] lat_a;
  logic [WIDTH-1:0] lat_b;
  logic             lat_setcc;
  logic             lat_usec;
  logic             lat_id;

  logic             resp_valid_q;
  logic             resp_id_q;
  logic [WIDTH-1:0] resp_result_q;
  logic [3:0]       resp_flags_q;

  logic             grant0;
  logic             grant1;
  logic             in_idle;

  // On a tie the requester that did not win last time gets the ALU.
  always_comb begin
    grant0  = bus.req0_valid && (!bus.req1_valid || last_grant);
    grant1  = bus.req1_valid && (!bus.req0_valid || !last_grant);
    in_idle = rst_n && (state == IDLE);
  end

  assign bus.req0_ready = in_idle && grant0;
  assign bus.req1_ready = in_idle && grant1;

  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_id     = resp_id_q;
  assign bus.resp_result = resp_result_q;
  assign bus.resp_flags  = resp_flags_q;

  // The ALU sees only latched values, so its inputs hold still for the whole settle window.
  assign alu_a     = lat_a;
  assign alu_b     = lat_b;
  assign alu_op    = lat_op;
  assign alu_cin   = lat_usec && cc_flags[3];
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      last_grant    <= 1'b1;
      lat_op        <= '0;
      lat_a         <= '0;
      lat_b         <= '0;
      lat_setcc     <= 1'b0;
      lat_usec      <= 1'b0;
      lat_id        <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_result_q <= '0;
      resp_flags_q  <= '0;
      cc_flags      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant1) begin
            lat_op     <= bus.req1_op;
            lat_a      <= bus.req1_a;
            lat_b      <= bus.req1_b;
            lat_setcc  <= bus.req1_setcc;
            lat_usec   <= bus.req1_usec;
            lat_id     <= 1'b1;
            last_grant <= 1'b1;
            cnt        <= '0;
            state      <= EXEC;
          end else if (grant0) begin
            lat_op     <= bus.req0_op;
            lat_a      <= bus.req0_a;
            lat_b      <= bus.req0_b;
            lat_setcc  <= bus.req0_setcc;
            lat_usec   <= bus.req0_usec;
            lat_id     <= 1'b0;
            last_grant <= 1'b0;
            cnt        <= '0;
            state      <= EXEC;
          end
        end

        EXEC: begin
          if (cnt == CNT_LAST) begin
            resp_valid_q  <= 1'b1;
            resp_id_q     <= lat_id;
            resp_result_q <= alu_result;
            resp_flags_q  <= {alu_c, alu_n, alu_v, alu_z};
            if (lat_setcc) begin
              cc_flags <= {alu_c, alu_n, alu_v, alu_z};
            end
            state <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            state        <= IDLE;
          end
        end

        default: begin
          resp_valid_q <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed and randomised bench for alu_issue_arbiter with a behavioural ALU on each instance;
// expected {id,flags,result} items go through a queue and are popped when a response appears.
module tb_alu_issue_arbiter;

  localparam int WIDTH = 32;
  localparam int OPW   = 4;
  localparam int W     = 1 + 4 + WIDTH;

  logic clk;
  logic rst_n;

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_issue_arbiter_if #(.WIDTH(WIDTH), .OPW(OPW)) b0 ();
  alu_issue_arbiter_if #(.WIDTH(WIDTH), .OPW(OPW)) b3 ();

  logic [WIDTH-1:0] alu_a0, alu_b0, alu_res0, alu_a3, alu_b3, alu_res3;
  logic [OPW-1:0]   alu_op0, alu_op3;
  logic             alu_cin0, alu_cin3;
  logic             c0, n0, v0, z0, c3, n3, v3, z3;
  logic [3:0]       cc0, cc3;
  logic [1:0]       st0, st3;

  function automatic logic [35:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic cin);
    logic [32:0] s;
    logic [31:0] r;
    logic        c;
    logic        v;
    s = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      4'd0: begin
        s = {1'b0, a} + {1'b0, b} + {32'd0, cin};
        r = s[31:0];
        c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = s[31:0];
        c = s[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'd2:    r = a & b;
      4'd3:    r = a ^ b;
      default: r = a | b;
    endcase
    return {c, r[31], v, (r == 32'd0), r};
  endfunction

  assign {c0, n0, v0, z0, alu_res0} = alu_f(alu_op0, alu_a0, alu_b0, alu_cin0);
  assign {c3, n3, v3, z3, alu_res3} = alu_f(alu_op3, alu_a3, alu_b3, alu_cin3);

  alu_issue_arbiter #(.WIDTH(WIDTH), .OPW(OPW), .EXEC_CYCLES(1)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0),
    .alu_a(alu_a0), .alu_b(alu_b0), .alu_cin(alu_cin0), .alu_op(alu_op0),
    .alu_result(alu_res0), .alu_c(c0), .alu_n(n0), .alu_v(v0), .alu_z(z0),
    .cc_flags(cc0), .dbg_state(st0)
  );

  alu_issue_arbiter #(.WIDTH(WIDTH), .OPW(OPW), .EXEC_CYCLES(3)) u3 (
    .clk(clk), .rst_n(rst_n), .bus(b3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_cin(alu_cin3), .alu_op(alu_op3),
    .alu_result(alu_res3), .alu_c(c3), .alu_n(n3), .alu_v(v3), .alu_z(z3),
    .cc_flags(cc3), .dbg_state(st3)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [3:0]   exp_cc;
  int           exp_last;
  int           n_checks;
  int           n_pass;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic set_req(input int n, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic sc, input logic uc);
    if (n == 0) begin
      b0.req0_valid = 1'b1; b0.req0_op = op; b0.req0_a = a; b0.req0_b = b;
      b0.req0_setcc = sc;   b0.req0_usec = uc;
    end else begin
      b0.req1_valid = 1'b1; b0.req1_op = op; b0.req1_a = a; b0.req1_b = b;
      b0.req1_setcc = sc;   b0.req1_usec = uc;
    end
  endtask

  task automatic issue(input int exp_id);
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        sc;
    logic        uc;
    logic [35:0] r;
    int          cycles;
    if (exp_id == 0) begin
      op = b0.req0_op; a = b0.req0_a; b = b0.req0_b; sc = b0.req0_setcc; uc = b0.req0_usec;
    end else begin
      op = b0.req1_op; a = b0.req1_a; b = b0.req1_b; sc = b0.req1_setcc; uc = b0.req1_usec;
    end
    r = alu_f(op, a, b, uc ? exp_cc[3] : 1'b0);
    exp_q.push_back({exp_id[0], r});
    if (sc) exp_cc = r[35:32];
    exp_last = exp_id;
    #1;
    chk("ready0_grant", b0.req0_ready, (exp_id == 0));
    chk("ready1_grant", b0.req1_ready, (exp_id == 1));
    @(posedge clk);
    @(negedge clk);
    b0.req0_valid = 1'b0;
    b0.req1_valid = 1'b0;
    chk("state_exec", st0, 2'd1);
    cycles = 0;
    while (!b0.resp_valid && cycles < 10) begin
      @(negedge clk);
      cycles++;
    end
    chk("latency", cycles, 1);
  endtask

  task automatic collect(input int stall);
    logic [W-1:0] e;
    logic [W-1:0] obs;
    chk("sb_depth", exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      obs = {b0.resp_id, b0.resp_flags, b0.resp_result};
      chk("resp_item", obs, e);
      chk("cc_flags", cc0, exp_cc);
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        chk("stall_valid", b0.resp_valid, 1'b1);
        chk("stall_item", {b0.resp_id, b0.resp_flags, b0.resp_result}, e);
        chk("stall_ready0", b0.req0_ready, 1'b0);
        chk("stall_ready1", b0.req1_ready, 1'b0);
      end
    end
    b0.req0_valid = 1'b0;
    b0.req1_valid = 1'b0;
    b0.resp_ready = 1'b1;
    @(negedge clk);
    b0.resp_ready = 1'b0;
    chk("resp_drop", b0.resp_valid, 1'b0);
    chk("state_idle", st0, 2'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cycles;
    logic        rv0;
    logic        rv1;
    int          eid;
    n_checks = 0;
    n_pass   = 0;
    exp_cc   = 4'd0;
    exp_last = 1;
    rst_n    = 1'b0;
    {b0.req0_valid, b0.req0_op, b0.req0_a, b0.req0_b, b0.req0_setcc, b0.req0_usec} = '0;
    {b0.req1_valid, b0.req1_op, b0.req1_a, b0.req1_b, b0.req1_setcc, b0.req1_usec} = '0;
    {b3.req0_valid, b3.req0_op, b3.req0_a, b3.req0_b, b3.req0_setcc, b3.req0_usec} = '0;
    {b3.req1_valid, b3.req1_op, b3.req1_a, b3.req1_b, b3.req1_setcc, b3.req1_usec} = '0;
    b0.resp_ready = 1'b0;
    b3.resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_resp_valid", b0.resp_valid, 1'b0);
    chk("rst_ready0", b0.req0_ready, 1'b0);
    chk("rst_cc", cc0, 4'd0);
    chk("rst_state", st0, 2'd0);
    chk("rst_alu_a", alu_a0, 32'd0);

    // Ties alternate starting with req0
    set_req(0, 4'd0, 32'd1, 32'd2, 1'b0, 1'b0);
    set_req(1, 4'd3, 32'hF0F0_0000, 32'h0F0F_0000, 1'b0, 1'b0);
    issue(0); collect(0);
    set_req(0, 4'd2, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0);
    set_req(1, 4'd1, 32'd10, 32'd3, 1'b0, 1'b0);
    issue(1); collect(0);
    set_req(0, 4'd0, 32'd7, 32'd9, 1'b0, 1'b0);
    set_req(1, 4'd4, 32'd1, 32'd2, 1'b0, 1'b0);
    issue(0); collect(0);

    // Single op from req0
    set_req(0, 4'd0, 32'd83, 32'd101, 1'b1, 1'b0);
    issue(0);
    chk("t2_result", b0.resp_result, 32'd184);
    chk("t2_flags", b0.resp_flags, 4'b0000);
    chk("t2_id", b0.resp_id, 1'b0);
    collect(0);

    // Signed overflow sets N and V in the CC register
    set_req(1, 4'd0, 32'h7FFF_FFFF, 32'd2, 1'b1, 1'b0);
    issue(1);
    chk("t4_result", b0.resp_result, 32'h8000_0001);
    chk("t4_flags", b0.resp_flags, 4'b0110);
    chk("t4_cc", cc0, 4'b0110);
    collect(0);

    // Carry produced by one op is consumed by the next
    set_req(0, 4'd0, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
    issue(0);
    chk("t5_cc", cc0, 4'b1001);
    collect(0);
    set_req(0, 4'd0, 32'd5, 32'd5, 1'b0, 1'b1);
    issue(0);
    chk("t5_cin", alu_cin0, 1'b1);
    chk("t5_result", b0.resp_result, 32'd11);
    collect(0);

    // Random mix of requesters, ops and CC usage
    for (int i = 0; i < 8; i++) begin
      rv0 = 1'($urandom_range(0, 1));
      rv1 = rv0 ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rv0) set_req(0, 4'($urandom_range(0, 4)), $urandom, $urandom,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (rv1) set_req(1, 4'($urandom_range(0, 4)), $urandom, $urandom,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (rv0 && rv1) eid = (exp_last == 0) ? 1 : 0;
      else            eid = rv0 ? 0 : 1;
      issue(eid);
      collect(0);
    end

    // Backpressure: consumer stalls while both requesters wait
    set_req(0, 4'd1, 32'd1000, 32'd1, 1'b0, 1'b0);
    issue(0);
    set_req(0, 4'd0, 32'd3, 32'd4, 1'b0, 1'b0);
    set_req(1, 4'd0, 32'd5, 32'd6, 1'b0, 1'b0);
    collect(5);

    // Reset in the middle of an op discards it and clears CC
    set_req(0, 4'd0, 32'h8000_0000, 32'd0, 1'b1, 1'b0);
    issue(0);
    chk("pre_rst_cc", cc0, 4'b0100);
    collect(0);
    set_req(0, 4'd0, 32'd1, 32'd1, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("mid_state", st0, 2'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", b0.resp_valid, 1'b0);
    chk("mid_rst_ready", b0.req0_ready, 1'b0);
    chk("mid_rst_cc", cc0, 4'd0);
    @(negedge clk);
    b0.req0_valid = 1'b0;
    rst_n = 1'b1;
    exp_cc = 4'd0;
    exp_last = 1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_valid", b0.resp_valid, 1'b0);
      chk("post_rst_state", st0, 2'd0);
    end

    // After reset req0 wins the first tie again
    set_req(0, 4'd0, 32'd20, 32'd22, 1'b0, 1'b0);
    set_req(1, 4'd0, 32'd30, 32'd33, 1'b0, 1'b0);
    issue(0);
    collect(0);

    // Three-cycle settle window
    b3.req1_valid = 1'b1; b3.req1_op = 4'd0; b3.req1_a = 32'd100; b3.req1_b = 32'd23;
    b3.req1_setcc = 1'b1; b3.req1_usec = 1'b0;
    #1;
    chk("x3_ready1", b3.req1_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    b3.req1_valid = 1'b0;
    cycles = 0;
    while (!b3.resp_valid && cycles < 10) begin
      @(negedge clk);
      cycles++;
    end
    chk("x3_latency", cycles, 3);
    chk("x3_item", {b3.resp_id, b3.resp_flags, b3.resp_result}, {1'b1, 4'b0000, 32'd123});
    chk("x3_cc", cc3, 4'b0000);
    b3.resp_ready = 1'b1;
    @(negedge clk);
    b3.resp_ready = 1'b0;
    chk("x3_drop", b3.resp_valid, 1'b0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
